multi_clip_controller: RTL and testbench
========================================

# multi_clip_controller

Parametrised record/playback sequencer for the audio looper datapath. Supports NUM_CLIPS independent clips of up to CLIP_WORDS samples each, and tracks the recorded length of every clip so playback stops at the end of recorded material. Sits between the synchronised user controls, the deserializer (microphone path), the serializer (speaker path) and the clip memory banks. Replaces the fixed two-clip, timer-driven controller.

## Interface
- NUM_CLIPS, 4, number of clips and memory banks (≥2)
- CLIP_WORDS, 65536, maximum samples per clip (≥2, ≤2^ADDR_WIDTH)
- ADDR_WIDTH, 16, memory address width
- SEL_WIDTH, $clog2(NUM_CLIPS), derived; do not override
- LEN_WIDTH, $clog2(CLIP_WORDS+1), derived; do not override

Ports:
- clock_i  in  1  100 MHz clock
- reset_i  in  1  Reset; asynchronous, active-low
- play_i  in  1  play command pulse, synchronised
- record_i  in  1  record command pulse, synchronised
- stop_i  in  1  abort command pulse, synchronised
- clip_sel_i  in  SEL_WIDTH  clip for the next command
- deser_valid_i  in  1  one-cycle pulse: new mic sample ready
- deser_enable_o  out  1  high while recording
- ser_start_o  out  1  one-cycle pulse: memory data valid, start shifting
- ser_done_i  in  1  one-cycle pulse: serializer finished a word
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  1 = write, 0 = read
- mem_en_o  out  NUM_CLIPS  one-hot bank enable
- active_clip_o  out  SEL_WIDTH  clip latched at command accept
- mode_o  out  2  0 idle, 1 play, 2 record
- busy_o  out  1  high in any non-IDLE state
- done_o  out  1  one-cycle pulse on completion or stop
- clip_valid_o  out  NUM_CLIPS  bit i set when clip i length ≠ 0

## Operation
- States: IDLE, REC_WAIT, REC_WRITE, PLAY_READ, PLAY_LATCH, PLAY_SEND, FINISH.
- IDLE: play_i has priority over record_i when both are high. Accept latches clip_sel_i into active_clip and clears the address counter to 0.
- Play of a clip with length 0: ignored, stays IDLE, no done_o.
- Commands other than stop_i are ignored while busy_o is high.
- Record flow:
  - REC_WAIT: deser_enable_o=1; on deser_valid_i go to REC_WRITE.
  - REC_WRITE: one cycle; mem_en_o[active]=1, mem_we_o=1, address k. Then increment the address.
  - If k==CLIP_WORDS-1, go to FINISH; otherwise return to REC_WAIT.
- Play flow:
  - PLAY_READ: mem_en_o[active]=1, mem_we_o=0.
  - PLAY_LATCH: one cycle for registered memory latency.
  - PLAY_SEND: ser_start_o pulses on entry, then wait for ser_done_i.
  - On ser_done_i, increment the address. If the new address equals len[active], go to FINISH; otherwise go to PLAY_READ.
- stop_i in any busy state: go to FINISH next cycle. An in-progress REC_WRITE still completes that cycle.
- FINISH: done_o=1 for one cycle, then IDLE.
  - On a record finish, len[active] = number of words written (0..CLIP_WORDS).
  - Stop during REC_WAIT with 0 words written sets length 0 and clears clip_valid_o.
- Outside REC_WRITE/PLAY_READ: mem_en_o=0, mem_we_o=0. mem_addr_o always shows the counter value.
- Width rules:
  - The counter is LEN_WIDTH wide; mem_addr_o is its low ADDR_WIDTH bits.
  - Lengths are LEN_WIDTH wide, so CLIP_WORDS itself is representable and the counter never wraps.

## Timing
- Reset values: all outputs 0; state IDLE; all lengths 0; active_clip 0.
- Reset asserted mid-operation aborts immediately. Recorded lengths are lost; no done_o.
- Command at cycle n → busy_o and mode_o at n+1.
- Record: deser_valid_i at cycle n → write strobe at n+1. Minimum sample spacing is 2 cycles; a deser_valid_i that arrives outside REC_WAIT is dropped.
- Play: PLAY_READ at t, ser_start_o at t+2, next PLAY_READ one cycle after ser_done_i.
- done_o occurs exactly one cycle after the final write, the final ser_done_i, or stop_i.

## Structure
- Package controller_pkg holds:
  - ctrl_state_t enum
  - ctrl_mode_t enum (IDLE=0, PLAY=1, RECORD=2)
- Sub-module addr_counter (LEN_WIDTH, clear/enable, terminal-compare output) provides the address counter.
- The length table stays in this module as a register array indexed by active_clip.

## Test plan
- NUM_CLIPS=4, CLIP_WORDS=8. Record clip 2 with 8 deser_valid_i pulses → writes to addresses 0..7 with only mem_en_o=4'b0100 active, done_o after the 8th write, clip_valid_o=4'b0100.
- Record clip 1 and stop after 3 samples → len=3. Play clip 1 → 3 reads (addresses 0,1,2), 3 ser_start_o pulses, then done_o.
- Play clip 0 while it is empty → busy_o stays 0 and no memory access occurs.
- play_i and record_i in the same cycle → mode_o=1 (play). record_i pulsed while busy → ignored.
- Stop in REC_WAIT before any sample → done_o, len=0, clip_valid_o bit cleared.
- Assert reset_i low during PLAY_SEND → all outputs 0 asynchronously, clip_valid_o=0 after release.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types for the multi-clip record/playback sequencer.
package controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC_WAIT   = 3'd1,
        ST_REC_WRITE  = 3'd2,
        ST_PLAY_READ  = 3'd3,
        ST_PLAY_LATCH = 3'd4,
        ST_PLAY_SEND  = 3'd5,
        ST_FINISH     = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_PLAY   = 2'd1,
        MODE_RECORD = 2'd2
    } ctrl_mode_t;

endpackage

// File: rtl/addr_counter.sv
// Clip address counter with clear/enable and a look-ahead terminal compare.
module addr_counter #(
    parameter int unsigned LEN_WIDTH = 17
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [LEN_WIDTH-1:0] term_i,
    output logic [LEN_WIDTH-1:0] count_o,
    output logic                 term_hit_c
);

    // Counter register; clear wins over enable.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (enable_i) begin
            count_o <= count_o + LEN_WIDTH'(1);
        end
    end

    // True when the value after the next increment reaches term_i (one bit wider so it never wraps).
    assign term_hit_c = (({1'b0, count_o} + (LEN_WIDTH + 1)'(1)) == {1'b0, term_i});

endmodule

// File: rtl/multi_clip_controller.sv
// Record/playback sequencer for NUM_CLIPS clips with per-clip recorded length tracking.
module multi_clip_controller
    import controller_pkg::*;
#(
    parameter int unsigned NUM_CLIPS  = 4,
    parameter int unsigned CLIP_WORDS = 65536,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_CLIPS),
    parameter int unsigned LEN_WIDTH  = $clog2(CLIP_WORDS + 1)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  play_i,
    input  logic                  record_i,
    input  logic                  stop_i,
    input  logic [SEL_WIDTH-1:0]  clip_sel_i,
    input  logic                  deser_valid_i,
    output logic                  deser_enable_o,
    output logic                  ser_start_o,
    input  logic                  ser_done_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [NUM_CLIPS-1:0]  mem_en_o,
    output logic [SEL_WIDTH-1:0]  active_clip_o,
    output logic [1:0]            mode_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NUM_CLIPS-1:0]  clip_valid_o
);

    ctrl_state_t          state_q, state_d;
    ctrl_mode_t           op_mode_q, op_mode_d;
    logic [SEL_WIDTH-1:0] active_q, active_d;
    logic                 accept;

    logic [LEN_WIDTH-1:0] clip_len_q [NUM_CLIPS];
    logic [NUM_CLIPS-1:0] clip_valid_q;

    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] term;
    logic                 term_hit_c;
    logic                 cnt_en;

    logic                 busy_d, deser_en_d, mem_we_d, ser_start_d, done_d;
    logic [NUM_CLIPS-1:0] mem_en_d;
    ctrl_mode_t           mode_d;

    // Record ends at the clip capacity, playback at the recorded length.
    assign term   = (op_mode_q == MODE_RECORD) ? LEN_WIDTH'(CLIP_WORDS) : clip_len_q[active_q];
    assign cnt_en = (state_q == ST_REC_WRITE) || ((state_q == ST_PLAY_SEND) && ser_done_i);

    addr_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clear_i    (accept),
        .enable_i   (cnt_en),
        .term_i     (term),
        .count_o    (count),
        .term_hit_c (term_hit_c)
    );

    // State, operation mode and latched clip registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            op_mode_q <= MODE_IDLE;
            active_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_mode_q <= op_mode_d;
            active_q  <= active_d;
        end
    end

    // Next-state logic and command acceptance; play outranks record, empty-clip play is dropped.
    always_comb begin
        state_d   = state_q;
        op_mode_d = op_mode_q;
        active_d  = active_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play_i) begin
                    if (clip_len_q[clip_sel_i] != '0) begin
                        state_d   = ST_PLAY_READ;
                        op_mode_d = MODE_PLAY;
                        active_d  = clip_sel_i;
                        accept    = 1'b1;
                    end
                end else if (record_i) begin
                    state_d   = ST_REC_WAIT;
                    op_mode_d = MODE_RECORD;
                    active_d  = clip_sel_i;
                    accept    = 1'b1;
                end
            end
            ST_REC_WAIT: begin
                if (stop_i) begin
                    state_d = ST_FINISH;
                end else if (deser_valid_i) begin
                    state_d = ST_REC_WRITE;
                end
            end
            ST_REC_WRITE: begin
                state_d = (stop_i || term_hit_c) ? ST_FINISH : ST_REC_WAIT;
            end
            ST_PLAY_READ: begin
                state_d = stop_i ? ST_FINISH : ST_PLAY_LATCH;
            end
            ST_PLAY_LATCH: begin
                state_d = stop_i ? ST_FINISH : ST_PLAY_SEND;
            end
            ST_PLAY_SEND: begin
                if (stop_i) begin
                    state_d = ST_FINISH;
                end else if (ser_done_i) begin
                    state_d = term_hit_c ? ST_FINISH : ST_PLAY_READ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        mode_d      = (state_d == ST_IDLE) ? MODE_IDLE : op_mode_d;
        deser_en_d  = (state_d == ST_REC_WAIT);
        mem_we_d    = (state_d == ST_REC_WRITE);
        mem_en_d    = '0;
        if ((state_d == ST_REC_WRITE) || (state_d == ST_PLAY_READ)) begin
            mem_en_d = NUM_CLIPS'(1) << active_d;
        end
        ser_start_d = (state_d == ST_PLAY_SEND) && (state_q != ST_PLAY_SEND);
        done_d      = (state_d == ST_FINISH);
    end

    // Registered control outputs.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_o         <= 1'b0;
            mode_o         <= 2'd0;
            deser_enable_o <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_en_o       <= '0;
            ser_start_o    <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            busy_o         <= busy_d;
            mode_o         <= mode_d;
            deser_enable_o <= deser_en_d;
            mem_we_o       <= mem_we_d;
            mem_en_o       <= mem_en_d;
            ser_start_o    <= ser_start_d;
            done_o         <= done_d;
        end
    end

    // Length table: a finished recording stores the number of words written.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < int'(NUM_CLIPS); i++) begin
                clip_len_q[i] <= '0;
            end
            clip_valid_q <= '0;
        end else if ((state_q == ST_FINISH) && (op_mode_q == MODE_RECORD)) begin
            clip_len_q[active_q]   <= count;
            clip_valid_q[active_q] <= (count != '0);
        end
    end

    assign mem_addr_o    = ADDR_WIDTH'(count);
    assign active_clip_o = active_q;
    assign clip_valid_o  = clip_valid_q;

endmodule

// File: tb/tb_multi_clip_controller.sv
// Directed bench for multi_clip_controller with a transaction-level memory scoreboard.
module tb_multi_clip_controller;

    localparam int unsigned NUM_CLIPS  = 4;
    localparam int unsigned CLIP_WORDS = 8;
    localparam int unsigned ADDR_WIDTH = 16;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        play_i = 1'b0, record_i = 1'b0, stop_i = 1'b0;
    logic [1:0]  clip_sel_i = 2'd0;
    logic        deser_valid_i = 1'b0, ser_done_i = 1'b0;
    logic        deser_enable_o, ser_start_o, mem_we_o, busy_o, done_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_en_o, clip_valid_o;
    logic [1:0]  active_clip_o, mode_o;

    multi_clip_controller #(
        .NUM_CLIPS  (NUM_CLIPS),
        .CLIP_WORDS (CLIP_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .play_i         (play_i),
        .record_i       (record_i),
        .stop_i         (stop_i),
        .clip_sel_i     (clip_sel_i),
        .deser_valid_i  (deser_valid_i),
        .deser_enable_o (deser_enable_o),
        .ser_start_o    (ser_start_o),
        .ser_done_i     (ser_done_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_en_o       (mem_en_o),
        .active_clip_o  (active_clip_o),
        .mode_o         (mode_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .clip_valid_o   (clip_valid_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [1:0]  clip;
        logic        we;
        logic [15:0] addr;
    } acc_t;

    acc_t exp_q[$];
    acc_t e;
    int   model_len [4];
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   start_seen = 0;
    int   exp_done = 0;
    bit   check_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = (model_len[i] != 0);
        return v;
    endfunction

    function automatic void expect_acc(int clip, bit we, int addr);
        acc_t a;
        a.clip = 2'(clip);
        a.we   = we;
        a.addr = 16'(addr);
        exp_q.push_back(a);
    endfunction

    task automatic cycle();
        @(posedge clock_i);
        #1;
    endtask

    // Per-cycle compare: memory accesses against the scoreboard, idle clip_valid against the length model.
    always @(negedge clock_i) begin
        if (reset_i && check_en) begin
            check("busy_vs_mode", 32'(busy_o), 32'(mode_o != 2'd0));
            if (mem_en_o != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem", 32'(mem_en_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_mem_en", 32'(mem_en_o), 32'(4'd1 << e.clip));
                    check("sb_mem_we", 32'(mem_we_o), 32'(e.we));
                    check("sb_mem_addr", 32'(mem_addr_o), 32'(e.addr));
                end
            end else begin
                check("we_without_en", 32'(mem_we_o), 32'd0);
            end
            if (!busy_o) check("sb_clip_valid", 32'(clip_valid_o), 32'(model_valid()));
            if (done_o) done_seen++;
            if (ser_start_o) start_seen++;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) model_len[i] = 0;

        // Reset values
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_mode", 32'(mode_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_valid", 32'(clip_valid_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;
        cycle();
        check_en = 1'b1;

        // Record clip 2 to capacity
        for (int i = 0; i < 8; i++) expect_acc(2, 1'b1, i);
        exp_done++;
        clip_sel_i = 2'd2; record_i = 1'b1; cycle(); record_i = 1'b0;
        check("rec_mode", 32'(mode_o), 32'd2);
        check("rec_busy", 32'(busy_o), 32'd1);
        check("rec_deser_en", 32'(deser_enable_o), 32'd1);
        check("rec_active", 32'(active_clip_o), 32'd2);
        for (int i = 0; i < 8; i++) begin
            deser_valid_i = 1'b1; cycle(); deser_valid_i = 1'b0;
            check("rec_we", 32'(mem_we_o), 32'd1);
            check("rec_en", 32'(mem_en_o), 32'b0100);
            check("rec_addr", 32'(mem_addr_o), 32'(i));
            cycle();
            if (i == 7) begin
                check("rec_full_done", 32'(done_o), 32'd1);
                model_len[2] = 8;
            end else begin
                check("rec_wait_done", 32'(done_o), 32'd0);
                check("rec_wait_en", 32'(deser_enable_o), 32'd1);
            end
        end
        cycle();
        check("rec_full_idle", 32'(busy_o), 32'd0);
        check("rec_full_valid", 32'(clip_valid_o), 32'b0100);

        // Record clip 1, commands while busy ignored, stop after 3 samples
        for (int i = 0; i < 3; i++) expect_acc(1, 1'b1, i);
        exp_done++;
        clip_sel_i = 2'd1; record_i = 1'b1; cycle(); record_i = 1'b0;
        clip_sel_i = 2'd3; record_i = 1'b1; play_i = 1'b1; cycle(); record_i = 1'b0; play_i = 1'b0;
        check("busy_cmd_active", 32'(active_clip_o), 32'd1);
        check("busy_cmd_mode", 32'(mode_o), 32'd2);
        for (int i = 0; i < 3; i++) begin
            deser_valid_i = 1'b1; cycle(); deser_valid_i = 1'b0;
            check("rec1_addr", 32'(mem_addr_o), 32'(i));
            check("rec1_en", 32'(mem_en_o), 32'b0010);
            cycle();
        end
        stop_i = 1'b1; cycle(); stop_i = 1'b0;
        check("rec1_stop_done", 32'(done_o), 32'd1);
        model_len[1] = 3;
        cycle();
        check("rec1_valid", 32'(clip_valid_o), 32'b0110);

        // Play clip 1: three words
        for (int i = 0; i < 3; i++) expect_acc(1, 1'b0, i);
        exp_done++;
        clip_sel_i = 2'd1; play_i = 1'b1; cycle(); play_i = 1'b0;
        check("play_mode", 32'(mode_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("play_read_en", 32'(mem_en_o), 32'b0010);
            check("play_read_we", 32'(mem_we_o), 32'd0);
            check("play_read_addr", 32'(mem_addr_o), 32'(i));
            cycle();
            check("play_latch_start", 32'(ser_start_o), 32'd0);
            cycle();
            check("play_send_start", 32'(ser_start_o), 32'd1);
            cycle();
            check("play_start_pulse", 32'(ser_start_o), 32'd0);
            ser_done_i = 1'b1; cycle(); ser_done_i = 1'b0;
            check("play_done", 32'(done_o), (i == 2) ? 32'd1 : 32'd0);
        end
        cycle();
        check("play_idle", 32'(busy_o), 32'd0);
        check("play_starts", 32'(start_seen), 32'd3);

        // Play of empty clip 0 is ignored
        clip_sel_i = 2'd0; play_i = 1'b1; cycle(); play_i = 1'b0;
        check("empty_busy", 32'(busy_o), 32'd0);
        check("empty_mode", 32'(mode_o), 32'd0);
        cycle();
        check("empty_busy2", 32'(busy_o), 32'd0);

        // Play beats record; record while busy ignored; stop in PLAY_LATCH
        expect_acc(2, 1'b0, 0);
        exp_done++;
        clip_sel_i = 2'd2; play_i = 1'b1; record_i = 1'b1; cycle(); play_i = 1'b0; record_i = 1'b0;
        check("prio_mode", 32'(mode_o), 32'd1);
        check("prio_en", 32'(mem_en_o), 32'b0100);
        clip_sel_i = 2'd3; record_i = 1'b1; cycle(); record_i = 1'b0;
        check("prio_busy_mode", 32'(mode_o), 32'd1);
        check("prio_busy_active", 32'(active_clip_o), 32'd2);
        stop_i = 1'b1; cycle(); stop_i = 1'b0;
        check("prio_stop_done", 32'(done_o), 32'd1);
        cycle();
        check("prio_valid", 32'(clip_valid_o), 32'b0110);
        check("prio_no_start", 32'(start_seen), 32'd3);

        // Stop in REC_WAIT before any sample clears clip 2
        exp_done++;
        clip_sel_i = 2'd2; record_i = 1'b1; cycle(); record_i = 1'b0;
        stop_i = 1'b1; cycle(); stop_i = 1'b0;
        check("empty_rec_done", 32'(done_o), 32'd1);
        model_len[2] = 0;
        cycle();
        check("empty_rec_valid", 32'(clip_valid_o), 32'b0010);

        // Reset during PLAY_SEND
        expect_acc(1, 1'b0, 0);
        clip_sel_i = 2'd1; play_i = 1'b1; cycle(); play_i = 1'b0;
        cycle();
        cycle();
        check("rst_send_start", 32'(ser_start_o), 32'd1);
        @(negedge clock_i);
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) model_len[i] = 0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_mode", 32'(mode_o), 32'd0);
        check("arst_start", 32'(ser_start_o), 32'd0);
        check("arst_active", 32'(active_clip_o), 32'd0);
        check("arst_valid", 32'(clip_valid_o), 32'd0);
        check("arst_addr", 32'(mem_addr_o), 32'd0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;
        cycle();
        check("post_rst_valid", 32'(clip_valid_o), 32'd0);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_done", 32'(done_o), 32'd0);

        // Record clip 3 with two samples after reset
        expect_acc(3, 1'b1, 0);
        expect_acc(3, 1'b1, 1);
        exp_done++;
        clip_sel_i = 2'd3; record_i = 1'b1; cycle(); record_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            deser_valid_i = 1'b1; cycle(); deser_valid_i = 1'b0;
            check("rec3_addr", 32'(mem_addr_o), 32'(i));
            cycle();
        end
        stop_i = 1'b1; cycle(); stop_i = 1'b0;
        check("rec3_done", 32'(done_o), 32'd1);
        model_len[3] = 2;
        cycle();
        check("rec3_valid", 32'(clip_valid_o), 32'b1000);
        cycle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("start_count", 32'(start_seen), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
